// File: rtl/fetch_predict_pkg.sv
// Shared definitions for the fetch stage and its branch target buffer.
//   - ResetPcDefault : default fetch address after reset.
//   - cnt_e          : 2-bit direction counter encodings (SNT/WNT/WT/ST).
//   - CntAlloc       : counter value written when a taken branch allocates an entry.
//   - cnt_inc/cnt_dec: saturating counter steps.
//   - cnt_taken      : direction predicted by a counter value.
package fetch_predict_pkg;

    localparam logic [31:0] ResetPcDefault = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        CntSnt = 2'b00,
        CntWnt = 2'b01,
        CntWt  = 2'b10,
        CntSt  = 2'b11
    } cnt_e;

    localparam logic [1:0] CntReset = CntWnt;
    localparam logic [1:0] CntAlloc = CntWt;

    function automatic logic [1:0] cnt_inc(input logic [1:0] c);
        return (c == CntSt) ? CntSt : c + 2'd1;
    endfunction

    function automatic logic [1:0] cnt_dec(input logic [1:0] c);
        return (c == CntSnt) ? CntSnt : c - 2'd1;
    endfunction

    // Upper half of the counter range predicts taken.
    function automatic logic cnt_taken(input logic [1:0] c);
        return c[1];
    endfunction

endpackage

// File: rtl/fetch_predict_if.sv
// Bundle of the fetch stage's memory, redirect, training and IF/ID signals.
//   master : the fetch stage (drives Instr_Mem_Addr and the *_IF outputs).
//   slave  : the surrounding pipeline / memory (drives everything else).
interface fetch_predict_if;

    logic        STALL;
    logic [31:0] Instr_Mem_Addr;
    logic [31:0] Instr_Mem_Data;
    logic        Redirect_Valid;
    logic [31:0] Redirect_PC;
    logic        Update_Valid;
    logic [31:0] Update_PC;
    logic [31:0] Update_Target;
    logic        Update_Taken;
    logic [31:0] Instr1_IF;
    logic [31:0] Instr_PC_IF;
    logic [31:0] Instr_PC_Plus4_IF;
    logic        Pred_Taken_IF;

    modport master (
        input  STALL,
        input  Instr_Mem_Data,
        input  Redirect_Valid,
        input  Redirect_PC,
        input  Update_Valid,
        input  Update_PC,
        input  Update_Target,
        input  Update_Taken,
        output Instr_Mem_Addr,
        output Instr1_IF,
        output Instr_PC_IF,
        output Instr_PC_Plus4_IF,
        output Pred_Taken_IF
    );

    modport slave (
        output STALL,
        output Instr_Mem_Data,
        output Redirect_Valid,
        output Redirect_PC,
        output Update_Valid,
        output Update_PC,
        output Update_Target,
        output Update_Taken,
        input  Instr_Mem_Addr,
        input  Instr1_IF,
        input  Instr_PC_IF,
        input  Instr_PC_Plus4_IF,
        input  Pred_Taken_IF
    );

endinterface

// File: rtl/fetch_predict_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
//   clk_i, rst_i      : clock, synchronous active-high reset (clears valids, counters to WNT).
//   lookup_pc_i       : PC looked up combinationally.
//   hit_o             : entry valid and tag matches.
//   pred_taken_o      : hit and counter predicts taken.
//   target_o          : stored target word address (PC[31:2]).
//   upd_*_i           : one synchronous training port keyed by the delay-slot PC.
// Entries must be a power of two, at least 2.
module fetch_predict_btb
    import fetch_predict_pkg::*;
#(
    parameter int unsigned Entries = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lookup_pc_i,
    output logic        hit_o,
    output logic        pred_taken_o,
    output logic [29:0] target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_taken_i
);

    localparam int unsigned IdxW = $clog2(Entries);
    localparam int unsigned TagW = 30 - IdxW;

    logic            valid_q  [Entries];
    logic [TagW-1:0] tag_q    [Entries];
    logic [29:0]     target_q [Entries];
    logic [1:0]      cnt_q    [Entries];

    logic [IdxW-1:0] lk_idx;
    logic [TagW-1:0] lk_tag;
    logic [IdxW-1:0] up_idx;
    logic [TagW-1:0] up_tag;
    logic            up_hit;

    assign lk_idx = lookup_pc_i[IdxW+1:2];
    assign lk_tag = lookup_pc_i[31:IdxW+2];
    assign up_idx = upd_pc_i[IdxW+1:2];
    assign up_tag = upd_pc_i[31:IdxW+2];

    assign hit_o        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken_o = hit_o && cnt_taken(cnt_q[lk_idx]);
    assign target_o     = target_q[lk_idx];

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Byte-offset bits never reach the tables.
    logic unused_low_bits;
    assign unused_low_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

    // Tag and target need no reset: they are only observed behind a set valid bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Entries); i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CntReset;
            end
        end else if (upd_valid_i) begin
            if (up_hit) begin
                if (upd_taken_i) begin
                    cnt_q[up_idx]    <= cnt_inc(cnt_q[up_idx]);
                    target_q[up_idx] <= upd_target_i[31:2];
                end else begin
                    cnt_q[up_idx] <= cnt_dec(cnt_q[up_idx]);
                end
            end else if (upd_taken_i) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target_i[31:2];
                cnt_q[up_idx]    <= CntAlloc;
            end
        end
    end

endmodule

// File: rtl/fetch_predict.sv
// Instruction fetch stage: PC register, next-PC selection and BTB-driven prediction.
//   CLK, RESET : clock, synchronous active-high reset (PC <= RESET_PC, BTB cleared).
//   bus        : fetch_predict_if.master -- memory address/data, execute redirect,
//                BTB training strobe and the IF/ID outputs (fetched word, PC, PC+4,
//                predicted-taken flag), all combinational from the PC and the BTB.
// Next PC priority: reset, redirect (even when stalled), stall, predicted target, PC+4.
module fetch_predict
    import fetch_predict_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = ResetPcDefault
) (
    input  logic            CLK,
    input  logic            RESET,
    fetch_predict_if.master bus
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        btb_hit;
    logic        btb_pred_taken;
    logic [29:0] btb_target;

    fetch_predict_btb #(
        .Entries (BTB_ENTRIES)
    ) u_btb (
        .clk_i        (CLK),
        .rst_i        (RESET),
        .lookup_pc_i  (pc_q),
        .hit_o        (btb_hit),
        .pred_taken_o (btb_pred_taken),
        .target_o     (btb_target),
        .upd_valid_i  (bus.Update_Valid),
        .upd_pc_i     (bus.Update_PC),
        .upd_target_i (bus.Update_Target),
        .upd_taken_i  (bus.Update_Taken)
    );

    logic unused_hit;
    assign unused_hit = btb_hit;

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (bus.Redirect_Valid) begin
            pc_d = {bus.Redirect_PC[31:2], 2'b00};
        end else if (bus.STALL) begin
            pc_d = pc_q;
        end else if (btb_pred_taken) begin
            pc_d = {btb_target, 2'b00};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.Instr_Mem_Addr    = pc_q;
    assign bus.Instr1_IF         = bus.Instr_Mem_Data;
    assign bus.Instr_PC_IF       = pc_q;
    assign bus.Instr_PC_Plus4_IF = pc_q + 32'd4;
    assign bus.Pred_Taken_IF     = btb_pred_taken;

endmodule

// File: tb/tb_fetch_predict.sv
// Bench for fetch_predict: directed stimulus, literal expectations for the test plan,
// and a behavioural model compared against the outputs on every falling edge.
module tb_fetch_predict;

    localparam logic [31:0] RstPc = 32'hBFC0_0000;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    fetch_predict_if bus ();

    fetch_predict #(
        .BTB_ENTRIES (16),
        .RESET_PC    (RstPc)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Combinational instruction memory: an arbitrary but address-unique pattern.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction
    assign bus.Instr_Mem_Data = memf(bus.Instr_Mem_Addr);

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h, required %h at %0t", name, got, want, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic        m_ok = 1'b0;
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_cnt   [16];

    function automatic bit m_pred(input logic [31:0] pc);
        int i;
        i = int'((pc / 4) % 16);
        return m_valid[i] && (m_tag[i] == pc / 64) && (m_cnt[i] >= 2);
    endfunction

    always @(posedge CLK) begin
        logic [31:0] nxt;
        int          i;
        if (RESET) begin
            m_pc = RstPc;
            m_ok = 1'b1;
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 0;
                m_cnt[k]   = 1;
            end
        end else if (m_ok) begin
            if (bus.Redirect_Valid)  nxt = bus.Redirect_PC & 32'hFFFF_FFFC;
            else if (bus.STALL)      nxt = m_pc;
            else if (m_pred(m_pc))   nxt = m_tgt[int'((m_pc / 4) % 16)];
            else                     nxt = m_pc + 4;
            if (bus.Update_Valid) begin
                i = int'((bus.Update_PC / 4) % 16);
                if (m_valid[i] && m_tag[i] == bus.Update_PC / 64) begin
                    if (bus.Update_Taken) begin
                        m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
                        m_tgt[i] = bus.Update_Target & 32'hFFFF_FFFC;
                    end else begin
                        m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
                    end
                end else if (bus.Update_Taken) begin
                    m_valid[i] = 1;
                    m_tag[i]   = bus.Update_PC / 64;
                    m_tgt[i]   = bus.Update_Target & 32'hFFFF_FFFC;
                    m_cnt[i]   = 2;
                end
            end
            m_pc = nxt;
        end
    end

    // Single compare process, every cycle once the model is initialised.
    always @(negedge CLK) begin
        if (m_ok) begin
            chk("model_addr",  bus.Instr_Mem_Addr,    m_pc);
            chk("model_pc",    bus.Instr_PC_IF,       m_pc);
            chk("model_plus4", bus.Instr_PC_Plus4_IF, m_pc + 32'd4);
            chk("model_instr", bus.Instr1_IF,         memf(m_pc));
            chk("model_pred",  {31'd0, bus.Pred_Taken_IF}, {31'd0, m_pred(m_pc)});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.STALL          = 1'b0;
        bus.Redirect_Valid = 1'b0;
        bus.Redirect_PC    = 32'd0;
        bus.Update_Valid   = 1'b0;
        bus.Update_PC      = 32'd0;
        bus.Update_Target  = 32'd0;
        bus.Update_Taken   = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.Redirect_Valid = 1'b1;
        bus.Redirect_PC    = pc;
        cyc();
        bus.Redirect_Valid = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        bus.Update_Valid  = 1'b1;
        bus.Update_PC     = pc;
        bus.Update_Target = tgt;
        bus.Update_Taken  = tk;
    endtask

    initial begin
        idle_inputs();
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;

        // 1. reset and sequential fetch
        chk("rst_pc",    bus.Instr_PC_IF,       32'hBFC0_0000);
        chk("rst_plus4", bus.Instr_PC_Plus4_IF, 32'hBFC0_0004);
        chk("rst_pred",  {31'd0, bus.Pred_Taken_IF}, 32'd0);
        cyc();
        chk("seq1", bus.Instr_PC_IF, 32'hBFC0_0004);
        cyc();
        chk("seq2", bus.Instr_PC_IF, 32'hBFC0_0008);

        // 2. stall
        bus.STALL = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_hold", bus.Instr_PC_IF, 32'hBFC0_0008);
        end
        bus.STALL = 1'b0;
        cyc();
        chk("stall_release", bus.Instr_PC_IF, 32'hBFC0_000C);

        // 3. train and predict
        train(32'hBFC0_0010, 32'hBFC0_0100, 1'b1);
        cyc();
        bus.Update_Valid = 1'b0;
        chk("train_pc",   bus.Instr_PC_IF, 32'hBFC0_0010);
        chk("train_pred", {31'd0, bus.Pred_Taken_IF}, 32'd1);
        cyc();
        chk("train_target", bus.Instr_PC_IF, 32'hBFC0_0100);

        // 4. hysteresis: 10 -> 01 (not taken)
        train(32'hBFC0_0010, 32'hBFC0_0100, 1'b0);
        redirect(32'hBFC0_0010);
        bus.Update_Valid = 1'b0;
        chk("hyst_wnt_pred", {31'd0, bus.Pred_Taken_IF}, 32'd0);
        cyc();
        chk("hyst_wnt_next", bus.Instr_PC_IF, 32'hBFC0_0014);
        // 01 -> 10 -> 11 -> 10
        train(32'hBFC0_0010, 32'hBFC0_0100, 1'b1);
        cyc();
        cyc();
        bus.Update_Taken = 1'b0;
        cyc();
        bus.Update_Valid = 1'b0;
        redirect(32'hBFC0_0010);
        chk("hyst_wt_pred", {31'd0, bus.Pred_Taken_IF}, 32'd1);
        cyc();
        chk("hyst_wt_next", bus.Instr_PC_IF, 32'hBFC0_0100);

        // 5. redirect priority over stall, low bits dropped, wrap
        bus.STALL = 1'b1;
        redirect(32'h0040_0003);
        chk("redir_stall", bus.Instr_PC_IF, 32'h0040_0000);
        redirect(32'hFFFF_FFFC);
        chk("redir_top",   bus.Instr_PC_IF,       32'hFFFF_FFFC);
        chk("redir_wrap4", bus.Instr_PC_Plus4_IF, 32'h0000_0000);
        bus.STALL = 1'b0;
        cyc();
        chk("wrap_pc", bus.Instr_PC_IF, 32'h0000_0000);

        // 6. aliasing: same index, different tag
        redirect(32'hBFC0_0050);
        chk("alias_pred", {31'd0, bus.Pred_Taken_IF}, 32'd0);
        cyc();
        chk("alias_next", bus.Instr_PC_IF, 32'hBFC0_0054);

        // Reset wins over stall, redirect and training in the same cycle
        bus.STALL = 1'b1;
        bus.Redirect_Valid = 1'b1;
        bus.Redirect_PC = 32'h0000_1234;
        train(32'hBFC0_0050, 32'h0000_9000, 1'b1);
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        idle_inputs();
        chk("rst_mid_pc",   bus.Instr_PC_IF, 32'hBFC0_0000);
        chk("rst_mid_pred", {31'd0, bus.Pred_Taken_IF}, 32'd0);
        redirect(32'hBFC0_0010);
        chk("rst_cleared", {31'd0, bus.Pred_Taken_IF}, 32'd0);
        redirect(32'hBFC0_0050);
        chk("rst_no_train", {31'd0, bus.Pred_Taken_IF}, 32'd0);

        // Same-cycle lookup sees old entry; training visible next cycle
        redirect(32'hBFC0_0010);
        train(32'hBFC0_0010, 32'hBFC0_0200, 1'b1);
        #1;
        chk("same_cycle_pred", {31'd0, bus.Pred_Taken_IF}, 32'd0);
        cyc();
        bus.Update_Valid = 1'b0;
        chk("same_cycle_next", bus.Instr_PC_IF, 32'hBFC0_0014);
        redirect(32'hBFC0_0010);
        chk("after_train_pred", {31'd0, bus.Pred_Taken_IF}, 32'd1);
        cyc();
        chk("after_train_tgt", bus.Instr_PC_IF, 32'hBFC0_0200);
        cyc();
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
